mc68k_reg_target: RTL and testbench

MC68K_REG_TARGET -- requirements
Module: mc68k_reg_target

---
 rtl/mc68k_reg_target_pkg.sv | 32 +++
 rtl/m68k_sync2.sv | 26 ++
 rtl/mc68k_reg_target.sv | 164 ++++++++++++++++
 tb/tb_mc68k_reg_target.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc68k_reg_target_pkg.sv
// Shared definitions for the 68000 register target: bus states, word
// register addresses, the ID constant and the byte-lane merge helper.
`timescale 1ns/1ps
package mc68k_reg_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_t;

    localparam logic [1:0]  ADDR_CTRL    = 2'd0;
    localparam logic [1:0]  ADDR_STATUS  = 2'd1;
    localparam logic [1:0]  ADDR_SCRATCH = 2'd2;
    localparam logic [1:0]  ADDR_ID      = 2'd3;

    localparam logic [15:0] ID_VALUE     = 16'hA712;
    localparam int          WAIT_CNT_W   = 3;

    // Replace only the byte lanes whose data strobe is asserted.
    function automatic logic [15:0] byte_merge(
        input logic [15:0] old_val,
        input logic [15:0] new_val,
        input logic        upd_hi,
        input logic        upd_lo
    );
        byte_merge = {upd_hi ? new_val[15:8] : old_val[15:8],
                      upd_lo ? new_val[7:0]  : old_val[7:0]};
    endfunction

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchronizer for an active-low asynchronous bus strobe; both
// stages reset to the negated (high) level.
`timescale 1ns/1ps
module m68k_sync2 (
    input  logic CLK40,
    input  logic nRESET,
    input  logic async_n,
    output logic sync_n
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= async_n;
            sync_reg <= meta_reg;
        end
    end

    assign sync_n = sync_reg;

endmodule

// File: rtl/mc68k_reg_target.sv
// 68000 asynchronous-bus slave with four word registers (CTRL, STATUS, SCRATCH,
// ID), programmable DTACK wait states and abort on early strobe negation.
`timescale 1ns/1ps
module mc68k_reg_target
    import mc68k_reg_target_pkg::*;
#(
    parameter int WAIT_CLKS = 2
) (
    input  logic        CLK40,
    input  logic        nRESET,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        RnW,
    input  logic        nCS,
    input  logic [1:0]  A,
    input  logic [15:0] D_IN,
    input  logic [15:0] STATUS_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        nDTACK,
    output logic [15:0] CTRL
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CLKS[WAIT_CNT_W-1:0];

    logic [2:0] strobe_raw;
    logic [2:0] strobe_sync;
    logic       as_n_sync;
    logic       uds_n_sync;
    logic       lds_n_sync;
    logic       ds_any;

    assign strobe_raw = {nAS, nUDS, nLDS};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            m68k_sync2 u_sync (
                .CLK40   (CLK40),
                .nRESET  (nRESET),
                .async_n (strobe_raw[gi]),
                .sync_n  (strobe_sync[gi])
            );
        end
    endgenerate

    assign as_n_sync  = strobe_sync[2];
    assign uds_n_sync = strobe_sync[1];
    assign lds_n_sync = strobe_sync[0];
    assign ds_any     = !uds_n_sync || !lds_n_sync;

    bus_state_t            state_reg;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg;
    logic                  rnw_reg;
    logic [1:0]            addr_reg;
    logic [15:0]           ctrl_reg;
    logic [15:0]           scratch_reg;
    logic [15:0]           dout_reg;
    logic                  doe_reg;
    logic                  dtack_n_reg;
    logic                  armed_reg;
    logic [1:0]            flush_reg;
    logic [15:0]           read_data;

    always_comb begin
        read_data = ID_VALUE;
        case (A)
            ADDR_CTRL:    read_data = ctrl_reg;
            ADDR_STATUS:  read_data = STATUS_IN;
            ADDR_SCRATCH: read_data = scratch_reg;
            default:      read_data = ID_VALUE;
        endcase
    end

    // armed_reg needs a genuine high sample of nAS: the synchronizer's reset
    // value does not count, so flush_reg waits until both stages have been
    // refilled from the bus. This keeps a strobe that straddles reset unseen.
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            rnw_reg      <= 1'b1;
            addr_reg     <= 2'd0;
            ctrl_reg     <= 16'h0000;
            scratch_reg  <= 16'h0000;
            dout_reg     <= 16'h0000;
            doe_reg      <= 1'b0;
            dtack_n_reg  <= 1'b1;
            armed_reg    <= 1'b0;
            flush_reg    <= 2'b00;
        end else begin
            flush_reg <= {flush_reg[0], 1'b1};
            if (as_n_sync && flush_reg[1]) begin
                armed_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    dtack_n_reg <= 1'b1;
                    doe_reg     <= 1'b0;
                    if (!as_n_sync && armed_reg) begin
                        armed_reg <= 1'b0;
                        if (!nCS) begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                            rnw_reg      <= RnW;
                            addr_reg     <= A;
                            if (RnW) begin
                                dout_reg <= read_data;
                                doe_reg  <= 1'b1;
                            end
                        end
                    end
                end

                ST_WAIT: begin
                    if (as_n_sync) begin
                        state_reg <= ST_IDLE;
                        doe_reg   <= 1'b0;
                    end else if (wait_cnt_reg == '0) begin
                        if (rnw_reg || ds_any) begin
                            state_reg   <= ST_ACK;
                            dtack_n_reg <= 1'b0;
                            if (!rnw_reg) begin
                                case (addr_reg)
                                    ADDR_CTRL:    ctrl_reg    <= byte_merge(ctrl_reg, D_IN,
                                                                            !uds_n_sync, !lds_n_sync);
                                    ADDR_SCRATCH: scratch_reg <= byte_merge(scratch_reg, D_IN,
                                                                            !uds_n_sync, !lds_n_sync);
                                    default: ;
                                endcase
                            end
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end

                ST_ACK: begin
                    if (as_n_sync) begin
                        state_reg   <= ST_RELEASE;
                        dtack_n_reg <= 1'b1;
                        doe_reg     <= 1'b0;
                    end
                end

                ST_RELEASE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign D_OUT  = dout_reg;
    assign D_OE   = doe_reg;
    assign nDTACK = dtack_n_reg;
    assign CTRL   = ctrl_reg;

endmodule

// File: tb/tb_mc68k_reg_target.sv
// Randomized bench for mc68k_reg_target: bus-cycle driver, register model and
// a DTACK-triggered scoreboard monitor.
`timescale 1ns/1ps
module tb_mc68k_reg_target;

    localparam int W = 2;

    logic        CLK40     = 1'b0;
    logic        nRESET    = 1'b0;
    logic        nAS       = 1'b1;
    logic        nUDS      = 1'b1;
    logic        nLDS      = 1'b1;
    logic        RnW       = 1'b1;
    logic        nCS       = 1'b1;
    logic [1:0]  A         = 2'd0;
    logic [15:0] D_IN      = 16'h0000;
    logic [15:0] STATUS_IN = 16'h0000;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic        nDTACK;
    logic [15:0] CTRL;

    always #12.5 CLK40 = ~CLK40;

    mc68k_reg_target #(.WAIT_CLKS(W)) dut (
        .CLK40     (CLK40),
        .nRESET    (nRESET),
        .nAS       (nAS),
        .nUDS      (nUDS),
        .nLDS      (nLDS),
        .RnW       (RnW),
        .nCS       (nCS),
        .A         (A),
        .D_IN      (D_IN),
        .STATUS_IN (STATUS_IN),
        .D_OUT     (D_OUT),
        .D_OE      (D_OE),
        .nDTACK    (nDTACK),
        .CTRL      (CTRL)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int txn    = 0;

    always @(posedge CLK40) cyc <= cyc + 1;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        int          start;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    // Reference register file
    logic [15:0] m_ctrl    = 16'h0000;
    logic [15:0] m_scratch = 16'h0000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] a, input logic [15:0] st);
        case (a)
            2'd0:    return m_ctrl;
            2'd1:    return st;
            2'd2:    return m_scratch;
            default: return 16'hA712;
        endcase
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] ds);
        logic [15:0] mask;
        mask = {{8{ds[1]}}, {8{ds[0]}}};
        if (a == 2'd0) m_ctrl    = (m_ctrl    & ~mask) | (d & mask);
        if (a == 2'd2) m_scratch = (m_scratch & ~mask) | (d & mask);
    endtask

    // Scoreboard monitor: every falling nDTACK must match a queued expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge CLK40);
            if (prev === 1'b1 && nDTACK === 1'b0) begin
                chk("ack_expected", {15'd0, exp_q.size() != 0}, 16'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ack_latency", 16'(cyc - e.start), 16'(e.lat));
                    chk("ack_doe", {15'd0, D_OE}, {15'd0, e.is_read});
                    if (e.is_read) chk("read_data", D_OUT, e.data);
                end
            end
            prev = nDTACK;
        end
    end

    // One complete bus cycle. ds = {UDS, LDS} asserted ds_delay clocks after
    // nAS; abort_at != 0 negates nAS at that clock with no acknowledge expected.
    task automatic bus_cycle(input bit rnw, input logic [1:0] a, input logic [15:0] data,
                             input logic [1:0] ds, input int ds_delay, input int abort_at);
        int          k;
        int          cnt;
        int          hold;
        bit          acked;
        bit          bad;
        exp_t        e;
        logic [15:0] st;
        st = 16'($urandom);
        @(negedge CLK40);
        STATUS_IN = st;
        A         = a;
        RnW       = rnw;
        D_IN      = data;
        nCS       = 1'b0;
        nAS       = 1'b0;
        if (abort_at == 0) begin
            e.is_read = rnw;
            e.data    = model_read(a, st);
            e.start   = cyc;
            e.lat     = (!rnw && ds_delay + 3 > W + 4) ? ds_delay + 3 : W + 4;
            exp_q.push_back(e);
        end
        k = 0;
        acked = 1'b0;
        while (!acked && k < 60) begin
            if (k == ds_delay) begin
                nUDS = ~ds[1];
                nLDS = ~ds[0];
            end
            if (abort_at != 0 && k == abort_at) break;
            @(negedge CLK40);
            k++;
            if (nDTACK === 1'b0) acked = 1'b1;
        end
        if (abort_at != 0) begin
            nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nCS = 1'b1;
            bad = acked;
            repeat (5) begin
                @(negedge CLK40);
                if (nDTACK !== 1'b1 || D_OE !== 1'b0) bad = 1'b1;
            end
            chk("abort_quiet", {15'd0, bad}, 16'd0);
        end else begin
            chk("ack_seen", {15'd0, acked}, 16'd1);
            if (!acked) exp_q.delete();
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge CLK40);
                if (acked) chk("dtack_hold", {15'd0, nDTACK}, 16'd0);
            end
            nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nCS = 1'b1;
            cnt = 0;
            while (nDTACK !== 1'b1 && cnt < 10) begin
                @(negedge CLK40);
                cnt++;
            end
            if (acked) begin
                chk("release_delay", 16'(cnt), 16'd3);
                chk("release_doe", {15'd0, D_OE}, 16'd0);
            end
            if (!rnw) model_write(a, data, ds);
            chk("ctrl_port", CTRL, m_ctrl);
        end
        txn++;
        $display("txn %0d rnw=%0b a=%0d data=%h ds=%b dly=%0d abort=%0d acked=%0b",
                 txn, rnw, a, data, ds, ds_delay, abort_at, acked);
    endtask

    task automatic unselected_cycle();
        bit bad;
        @(negedge CLK40);
        nCS = 1'b1; A = 2'd0; RnW = 1'b1; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            @(negedge CLK40);
            if (nDTACK !== 1'b1 || D_OE !== 1'b0) bad = 1'b1;
        end
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        repeat (3) begin
            @(negedge CLK40);
            if (nDTACK !== 1'b1 || D_OE !== 1'b0) bad = 1'b1;
        end
        chk("unselected_quiet", {15'd0, bad}, 16'd0);
        txn++;
        $display("txn %0d unselected strobe", txn);
    endtask

    task automatic reset_mid_ack();
        exp_t e;
        bit   acked;
        bit   bad;
        int   k;
        @(negedge CLK40);
        STATUS_IN = 16'h0F0F; A = 2'd0; RnW = 1'b1; nCS = 1'b0;
        nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        e.is_read = 1'b1; e.data = m_ctrl; e.start = cyc; e.lat = W + 4;
        exp_q.push_back(e);
        acked = 1'b0;
        k = 0;
        while (!acked && k < 40) begin
            @(negedge CLK40);
            k++;
            if (nDTACK === 1'b0) acked = 1'b1;
        end
        chk("rst_ack_seen", {15'd0, acked}, 16'd1);
        #3 nRESET = 1'b0;
        #1;
        chk("rst_dtack", {15'd0, nDTACK}, 16'd1);
        chk("rst_doe", {15'd0, D_OE}, 16'd0);
        chk("rst_dout", D_OUT, 16'h0000);
        chk("rst_ctrl", CTRL, 16'h0000);
        m_ctrl = 16'h0000;
        m_scratch = 16'h0000;
        @(negedge CLK40);
        @(negedge CLK40);
        #3 nRESET = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            @(negedge CLK40);
            if (nDTACK !== 1'b1 || D_OE !== 1'b0) bad = 1'b1;
        end
        chk("post_reset_quiet", {15'd0, bad}, 16'd0);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nCS = 1'b1;
        repeat (3) @(negedge CLK40);
        txn++;
        $display("txn %0d reset during ACK", txn);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rnw;
        logic [1:0]  a;
        logic [15:0] d;
        logic [1:0]  ds;
        int          dly;
        int          ab;
        int          kind;

        repeat (3) @(negedge CLK40);
        chk("reset_dtack", {15'd0, nDTACK}, 16'd1);
        chk("reset_doe", {15'd0, D_OE}, 16'd0);
        chk("reset_dout", D_OUT, 16'h0000);
        chk("reset_ctrl", CTRL, 16'h0000);
        nRESET = 1'b1;
        repeat (4) @(negedge CLK40);

        bus_cycle(1'b1, 2'd3, 16'h0000, 2'b11, 0, 0);
        bus_cycle(1'b0, 2'd0, 16'h1234, 2'b01, 0, 0);
        chk("ctrl_byte_write", CTRL, 16'h0034);
        bus_cycle(1'b0, 2'd0, 16'hBEEF, 2'b11, 0, 0);
        chk("ctrl_word_write", CTRL, 16'hBEEF);
        bus_cycle(1'b0, 2'd2, 16'hC3A5, 2'b11, 6, 0);
        bus_cycle(1'b1, 2'd2, 16'h0000, 2'b11, 0, 0);
        bus_cycle(1'b0, 2'd2, 16'h5555, 2'b11, 1000, 4);
        bus_cycle(1'b1, 2'd2, 16'h0000, 2'b11, 0, 0);
        bus_cycle(1'b1, 2'd1, 16'h0000, 2'b11, 0, 0);
        unselected_cycle();
        reset_mid_ack();
        bus_cycle(1'b1, 2'd2, 16'h0000, 2'b11, 0, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            rnw  = $urandom_range(0, 1) != 0;
            a    = 2'($urandom_range(0, 3));
            d    = 16'($urandom);
            ds   = 2'($urandom_range(1, 3));
            dly  = $urandom_range(0, 6);
            ab   = 0;
            if (kind == 0) begin
                unselected_cycle();
            end else begin
                if (kind == 1) begin
                    rnw = 1'b0;
                    dly = 1000;
                    ab  = $urandom_range(2, 8);
                end
                bus_cycle(rnw, a, d, ds, dly, ab);
            end
        end

        repeat (5) @(negedge CLK40);
        chk("queue_drain", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
